// File: rtl/i2c_slave_reg_seq.sv
// i2c_slave_reg_seq: turns the I2C slave byte controller into a byte-addressed
// register-file slave ("pointer, then data" protocol).
//   Byte-controller side: cmd_ack/slave_addressed/rx_byte/ack_out/tx_load/bus_stop in;
//                         txr_ok/rxr_ok/ack_in/tx_byte out.
//   Register bus side:    reg_req/reg_wr/reg_addr/reg_wdata out; reg_rdata/reg_ack in.
//   Status:               ovf (dropped received byte pulse), ptr (current pointer).
module i2c_slave_reg_seq #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_en,
  input  logic          cmd_ack,
  input  logic          slave_addressed,
  input  logic [7:0]    rx_byte,
  input  logic          ack_out,
  input  logic          tx_load,
  input  logic          bus_stop,
  output logic          txr_ok,
  output logic          rxr_ok,
  output logic          ack_in,
  output logic [7:0]    tx_byte,
  output logic          reg_req,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  input  logic [7:0]    reg_rdata,
  input  logic          reg_ack,
  output logic          ovf,
  output logic [AW-1:0] ptr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_PTR   = 3'd1,
    W_DATA  = 3'd2,
    W_BUS   = 3'd3,
    R_FETCH = 3'd4,
    R_READY = 3'd5,
    R_SENT  = 3'd6
  } state_t;

  // Bus-level events that restart the sequencer; also the latched-event encoding.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_STOP = 2'd1,
    EV_AE_W = 2'd2,
    EV_AE_R = 2'd3
  } ev_t;

  state_t        state, state_n;
  ev_t           pend, pend_n;
  ev_t           ev, apply;
  logic [AW-1:0] ptr_n;
  logic [7:0]    tx_byte_n, reg_wdata_n;
  logic          txr_ok_n, reg_req_n, reg_wr_n, ovf_n;
  logic          ae, de;

  assign ae       = cmd_ack & slave_addressed;
  assign de       = cmd_ack & ~slave_addressed;
  assign ack_in   = ~rx_en;
  assign rxr_ok   = (state != W_BUS);
  assign reg_addr = ptr;

  // STOP outranks a simultaneous address event.
  always_comb begin
    if (bus_stop)      ev = EV_STOP;
    else if (ae)       ev = rx_byte[0] ? EV_AE_R : EV_AE_W;
    else               ev = EV_NONE;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    ptr_n       = ptr;
    tx_byte_n   = tx_byte;
    txr_ok_n    = txr_ok;
    reg_req_n   = reg_req;
    reg_wr_n    = reg_wr;
    reg_wdata_n = reg_wdata;
    ovf_n       = 1'b0;
    apply       = EV_NONE;

    case (state)
      // Outstanding write always completes; a bus event is latched until then.
      W_BUS: begin
        if (de) ovf_n = 1'b1;
        if (reg_ack) begin
          reg_req_n = 1'b0;
          ptr_n     = ptr + AW'(1);
          state_n   = W_DATA;
          apply     = (ev != EV_NONE) ? ev : pend;
          pend_n    = EV_NONE;
        end else if (ev != EV_NONE) begin
          pend_n = ev;
        end
      end
      // Outstanding read always completes; data is dropped if an event is pending.
      R_FETCH: begin
        if (reg_ack) begin
          reg_req_n = 1'b0;
          pend_n    = EV_NONE;
          if (ev == EV_NONE && pend == EV_NONE) begin
            tx_byte_n = reg_rdata;
            txr_ok_n  = 1'b1;
            state_n   = R_READY;
          end else begin
            apply = (ev != EV_NONE) ? ev : pend;
          end
        end else if (ev != EV_NONE) begin
          pend_n = ev;
        end
      end
      default: begin
        if (ev != EV_NONE) begin
          apply = ev;
        end else begin
          case (state)
            W_PTR: begin
              if (de) begin
                ptr_n   = rx_byte[AW-1:0];
                state_n = W_DATA;
              end
            end
            W_DATA: begin
              if (de && rx_en) begin
                reg_wdata_n = rx_byte;
                reg_req_n   = 1'b1;
                reg_wr_n    = 1'b1;
                state_n     = W_BUS;
              end
            end
            R_READY: begin
              if (tx_load) begin
                txr_ok_n = 1'b0;
                ptr_n    = ptr + AW'(1);
                state_n  = R_SENT;
              end
            end
            R_SENT: begin
              if (de) begin
                if (!ack_out) begin
                  reg_req_n = 1'b1;
                  reg_wr_n  = 1'b0;
                  state_n   = R_FETCH;
                end else begin
                  state_n = IDLE;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Apply a bus event as if it occurred in IDLE; pointer is always retained.
    case (apply)
      EV_STOP: begin
        state_n  = IDLE;
        txr_ok_n = 1'b0;
      end
      EV_AE_W: begin
        state_n  = W_PTR;
        txr_ok_n = 1'b0;
      end
      EV_AE_R: begin
        state_n   = R_FETCH;
        txr_ok_n  = 1'b0;
        reg_req_n = 1'b1;
        reg_wr_n  = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= EV_NONE;
      ptr       <= '0;
      tx_byte   <= '0;
      txr_ok    <= 1'b0;
      reg_req   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      ptr       <= ptr_n;
      tx_byte   <= tx_byte_n;
      txr_ok    <= txr_ok_n;
      reg_req   <= reg_req_n;
      reg_wr    <= reg_wr_n;
      reg_wdata <= reg_wdata_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg_seq.sv
// Directed testbench for i2c_slave_reg_seq with a negedge register-bus responder.
module tb_i2c_slave_reg_seq;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, rx_en, cmd_ack, slave_addressed, ack_out, tx_load, bus_stop;
  logic [7:0]    rx_byte;
  logic          txr_ok, rxr_ok, ack_in, reg_req, reg_wr, ovf;
  logic [7:0]    tx_byte, reg_wdata, reg_rdata;
  logic [AW-1:0] reg_addr, ptr;
  logic          reg_ack;

  int total = 0;
  int bad   = 0;

  // Responder state and logs
  logic [7:0] mem [16];
  int         ack_dly = 2;
  int         cnt = 0;
  int         ovf_cnt = 0;
  int         req_cyc = 0;
  int         wr_n = 0;
  int         rd_n = 0;
  logic [3:0] wr_a [64];
  logic [7:0] wr_d [64];
  logic [3:0] rd_a [64];

  i2c_slave_reg_seq #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .cmd_ack(cmd_ack),
    .slave_addressed(slave_addressed), .rx_byte(rx_byte), .ack_out(ack_out),
    .tx_load(tx_load), .bus_stop(bus_stop), .txr_ok(txr_ok), .rxr_ok(rxr_ok),
    .ack_in(ack_in), .tx_byte(tx_byte), .reg_req(reg_req), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .ovf(ovf), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Register file model: acks after ack_dly+1 negedges of reg_req, logs accesses.
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      reg_ack = 1'b0;
      if (ovf === 1'b1) ovf_cnt++;
      if (rst) begin
        cnt = 0;
      end else if (reg_req) begin
        req_cyc++;
        if (cnt >= ack_dly) begin
          reg_ack = 1'b1;
          cnt = 0;
          if (reg_wr) begin
            mem[reg_addr] = reg_wdata;
            if (wr_n < 64) begin wr_a[wr_n] = reg_addr; wr_d[wr_n] = reg_wdata; end
            wr_n++;
          end else begin
            reg_rdata = mem[reg_addr];
            if (rd_n < 64) rd_a[rd_n] = reg_addr;
            rd_n++;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ae(input logic [7:0] b);
    cmd_ack = 1'b1; slave_addressed = 1'b1; rx_byte = b;
    step();
    cmd_ack = 1'b0; slave_addressed = 1'b0;
  endtask

  task automatic de(input logic [7:0] b, input logic ao);
    cmd_ack = 1'b1; slave_addressed = 1'b0; rx_byte = b; ack_out = ao;
    step();
    cmd_ack = 1'b0; ack_out = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_stop = 1'b1; step(); bus_stop = 1'b0;
  endtask

  task automatic pulse_load();
    tx_load = 1'b1; step(); tx_load = 1'b0;
  endtask

  task automatic wait_req_low(input string nm);
    int n = 0;
    while (reg_req === 1'b1 && n < 200) begin step(); n++; end
    total++;
    if (reg_req !== 1'b0) begin
      bad++; $display("FAIL %s: reg_req got %b want 0 within 200 cycles", nm, reg_req);
    end
  endtask

  task automatic wait_txr(input string nm);
    int n = 0;
    while (txr_ok !== 1'b1 && n < 200) begin step(); n++; end
    total++;
    if (txr_ok !== 1'b1) begin
      bad++; $display("FAIL %s: txr_ok got %b want 1 within 200 cycles", nm, txr_ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    total++; if (ptr !== 4'h0)      begin bad++; $display("FAIL rst_ptr: got %h want 0", ptr); end
    total++; if (txr_ok !== 1'b0)   begin bad++; $display("FAIL rst_txr_ok: got %b want 0", txr_ok); end
    total++; if (rxr_ok !== 1'b1)   begin bad++; $display("FAIL rst_rxr_ok: got %b want 1", rxr_ok); end
    total++; if (reg_req !== 1'b0 || reg_wr !== 1'b0 || ovf !== 1'b0)
      begin bad++; $display("FAIL rst_bus: got req=%b wr=%b ovf=%b want 0 0 0", reg_req, reg_wr, ovf); end
    total++; if (tx_byte !== 8'h00 || reg_wdata !== 8'h00)
      begin bad++; $display("FAIL rst_bytes: got tx=%h wd=%h want 00 00", tx_byte, reg_wdata); end
    total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dut.state); end
    total++; if (ack_in !== 1'b0)   begin bad++; $display("FAIL rst_ack_in: got %b want 0", ack_in); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    int w0 = wr_n;
    int o0 = ovf_cnt;
    ack_dly = 2;
    ae(8'hA0);
    de(8'h03, 1'b0);
    total++; if (ptr !== 4'h3) begin bad++; $display("FAIL wr_ptr_set: got %h want 3", ptr); end
    de(8'h55, 1'b0);
    total++; if (reg_req !== 1'b1 || reg_wr !== 1'b1 || reg_addr !== 4'h3 || rxr_ok !== 1'b0)
      begin bad++; $display("FAIL wr_req: got req=%b wr=%b addr=%h rxr=%b want 1 1 3 0", reg_req, reg_wr, reg_addr, rxr_ok); end
    wait_req_low("wr_first");
    de(8'h66, 1'b0);
    wait_req_low("wr_second");
    pulse_stop();
    total++; if (wr_n - w0 !== 2) begin bad++; $display("FAIL wr_count: got %0d want 2", wr_n - w0); end
    total++; if (wr_a[w0] !== 4'h3 || wr_d[w0] !== 8'h55)
      begin bad++; $display("FAIL wr_byte0: got %h=%h want 3=55", wr_a[w0], wr_d[w0]); end
    total++; if (wr_a[w0+1] !== 4'h4 || wr_d[w0+1] !== 8'h66)
      begin bad++; $display("FAIL wr_byte1: got %h=%h want 4=66", wr_a[w0+1], wr_d[w0+1]); end
    total++; if (ptr !== 4'h5) begin bad++; $display("FAIL wr_ptr_end: got %h want 5", ptr); end
    total++; if (ovf_cnt !== o0) begin bad++; $display("FAIL wr_ovf: got %0d want 0", ovf_cnt - o0); end
  endtask

  task automatic test_read();
    int r0 = rd_n;
    ae(8'hA0);
    de(8'h0E, 1'b0);
    ae(8'hA1);
    total++; if (reg_req !== 1'b1 || reg_wr !== 1'b0 || reg_addr !== 4'hE)
      begin bad++; $display("FAIL rd_req0: got req=%b wr=%b addr=%h want 1 0 e", reg_req, reg_wr, reg_addr); end
    wait_txr("rd_fetch0");
    total++; if (tx_byte !== 8'h11) begin bad++; $display("FAIL rd_byte0: got %h want 11", tx_byte); end
    pulse_load();
    total++; if (ptr !== 4'hF || txr_ok !== 1'b0)
      begin bad++; $display("FAIL rd_load0: got ptr=%h txr=%b want f 0", ptr, txr_ok); end
    de(8'h00, 1'b0);
    wait_txr("rd_fetch1");
    total++; if (tx_byte !== 8'h22) begin bad++; $display("FAIL rd_byte1: got %h want 22", tx_byte); end
    pulse_load();
    total++; if (ptr !== 4'h0) begin bad++; $display("FAIL rd_wrap: got %h want 0", ptr); end
    de(8'h00, 1'b1);
    total++; if (dut.state !== 3'd0 || reg_req !== 1'b0)
      begin bad++; $display("FAIL rd_nack_idle: got state=%0d req=%b want 0 0", dut.state, reg_req); end
    total++; if (rd_n - r0 !== 2 || rd_a[r0] !== 4'hE || rd_a[r0+1] !== 4'hF)
      begin bad++; $display("FAIL rd_addrs: got n=%0d a0=%h a1=%h want 2 e f", rd_n - r0, rd_a[r0], rd_a[r0+1]); end
    pulse_stop();
  endtask

  task automatic test_overrun();
    int w0 = wr_n;
    int o0 = ovf_cnt;
    ae(8'hA0);
    de(8'h08, 1'b0);
    ack_dly = 50;
    de(8'h33, 1'b0);
    repeat (5) step();
    de(8'h77, 1'b0);
    total++; if (ovf !== 1'b1 || reg_req !== 1'b1)
      begin bad++; $display("FAIL ovr_pulse: got ovf=%b req=%b want 1 1", ovf, reg_req); end
    wait_req_low("ovr_done");
    ack_dly = 2;
    total++; if (ovf_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", ovf_cnt - o0); end
    total++; if (wr_n - w0 !== 1 || wr_a[w0] !== 4'h8 || wr_d[w0] !== 8'h33)
      begin bad++; $display("FAIL ovr_write: got n=%0d %h=%h want 1 8=33", wr_n - w0, wr_a[w0], wr_d[w0]); end
    total++; if (ptr !== 4'h9) begin bad++; $display("FAIL ovr_ptr: got %h want 9", ptr); end
    pulse_stop();
  endtask

  task automatic test_rx_nack();
    int q0 = req_cyc;
    int w0 = wr_n;
    rx_en = 1'b0;
    ae(8'hA0);
    de(8'h02, 1'b0);
    total++; if (ack_in !== 1'b1) begin bad++; $display("FAIL nack_ack_in: got %b want 1", ack_in); end
    de(8'h99, 1'b0);
    repeat (5) step();
    total++; if (req_cyc !== q0 || wr_n !== w0)
      begin bad++; $display("FAIL nack_noreq: got req_cycles=%0d writes=%0d want 0 0", req_cyc - q0, wr_n - w0); end
    total++; if (ptr !== 4'h2) begin bad++; $display("FAIL nack_ptr: got %h want 2", ptr); end
    rx_en = 1'b1;
    pulse_stop();
  endtask

  task automatic test_stop_in_fetch();
    int n = 0;
    logic held_ok = 1'b1;
    ack_dly = 6;
    ae(8'hA1);
    total++; if (reg_req !== 1'b1 || reg_addr !== 4'h2)
      begin bad++; $display("FAIL sf_req: got req=%b addr=%h want 1 2", reg_req, reg_addr); end
    pulse_stop();
    while (reg_ack !== 1'b1 && n < 100) begin
      if (reg_req !== 1'b1 || txr_ok !== 1'b0) held_ok = 1'b0;
      step(); n++;
    end
    total++; if (held_ok !== 1'b1 || reg_ack !== 1'b1)
      begin bad++; $display("FAIL sf_hold: got held=%b ack=%b want 1 1", held_ok, reg_ack); end
    total++; if (dut.state !== 3'd0 || reg_req !== 1'b0 || txr_ok !== 1'b0 || ptr !== 4'h2)
      begin bad++; $display("FAIL sf_after: got state=%0d req=%b txr=%b ptr=%h want 0 0 0 2", dut.state, reg_req, txr_ok, ptr); end
    ack_dly = 2;
  endtask

  task automatic test_back_to_back();
    int w0 = wr_n;
    int r0 = rd_n;
    ack_dly = 10;
    ae(8'hA0);
    de(8'h0A, 1'b0);
    de(8'h5A, 1'b0);
    ae(8'hA1);
    wait_txr("b2b_read");
    total++; if (wr_n - w0 !== 1 || wr_a[w0] !== 4'hA || wr_d[w0] !== 8'h5A)
      begin bad++; $display("FAIL b2b_write: got n=%0d %h=%h want 1 a=5a", wr_n - w0, wr_a[w0], wr_d[w0]); end
    total++; if (rd_n - r0 !== 1 || rd_a[r0] !== 4'hB || tx_byte !== 8'hBB)
      begin bad++; $display("FAIL b2b_read: got n=%0d addr=%h tx=%h want 1 b bb", rd_n - r0, rd_a[r0], tx_byte); end
    pulse_stop();
    total++; if (txr_ok !== 1'b0 || dut.state !== 3'd0 || ptr !== 4'hB)
      begin bad++; $display("FAIL b2b_stop: got txr=%b state=%0d ptr=%h want 0 0 b", txr_ok, dut.state, ptr); end
    ack_dly = 2;
  endtask

  task automatic test_reset_mid();
    ack_dly = 50;
    ae(8'hA0);
    de(8'h05, 1'b0);
    de(8'hAB, 1'b0);
    total++; if (reg_req !== 1'b1 || rxr_ok !== 1'b0)
      begin bad++; $display("FAIL rm_pre: got req=%b rxr=%b want 1 0", reg_req, rxr_ok); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (reg_req !== 1'b0 || rxr_ok !== 1'b1 || ptr !== 4'h0 || dut.state !== 3'd0 || reg_wdata !== 8'h00)
      begin bad++; $display("FAIL rm_post: got req=%b rxr=%b ptr=%h state=%0d wd=%h want 0 1 0 0 00",
                            reg_req, rxr_ok, ptr, dut.state, reg_wdata); end
    ack_dly = 2;
    step();
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; cmd_ack = 1'b0; slave_addressed = 1'b0;
    rx_byte = 8'h00; ack_out = 1'b0; tx_load = 1'b0; bus_stop = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2]  = 8'h42;
    mem[11] = 8'hBB;
    mem[14] = 8'h11;
    mem[15] = 8'h22;
    test_reset();
    test_write();
    test_read();
    test_overrun();
    test_rx_nack();
    test_stop_in_fetch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
